// File: rtl/nios2_cpu_mul_combine_if.sv
// ---------------------------------------------------------------------------
// nios2_cpu_mul_combine_if
//   Bundles the partial-product input handshake, the result output handshake,
//   the flush strobe and the completed-operation counter of the multiplier
//   combine stage.
//
//   Parameters (must match the nios2_cpu_mul_combine instance):
//     HALF_W  half-operand width; partial products and result are 2*HALF_W
//     TAG_W   destination register tag width
//     CNT_W   completed-multiply counter width
//
//   Modports:
//     master  producer/consumer side: drives in_*, flush, out_ready
//     slave   combine stage: drives in_ready, out_*, done_cnt
// ---------------------------------------------------------------------------
interface nios2_cpu_mul_combine_if #(
    parameter int HALF_W = 16,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
);
    logic [2*HALF_W-1:0] in_p1;
    logic [2*HALF_W-1:0] in_p2;
    logic [2*HALF_W-1:0] in_p3;
    logic [TAG_W-1:0]    in_tag;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [2*HALF_W-1:0] out_result;
    logic [TAG_W-1:0]    out_tag;
    logic [3:0]          out_par;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_W-1:0]    done_cnt;

    modport master (
        output in_p1, in_p2, in_p3, in_tag, in_valid, flush, out_ready,
        input  in_ready, out_result, out_tag, out_par, out_valid, done_cnt
    );

    modport slave (
        input  in_p1, in_p2, in_p3, in_tag, in_valid, flush, out_ready,
        output in_ready, out_result, out_tag, out_par, out_valid, done_cnt
    );
endinterface

// File: rtl/nios2_cpu_mul_combine.sv
// ---------------------------------------------------------------------------
// nios2_cpu_mul_combine
//   Downstream stage of the CPU multiplier cell. Combines the three
//   registered 16x16 partial products (lo*lo, lo*hi, hi*lo) into the 32-bit
//   low word of the product through a 2-stage valid/ready pipeline that
//   carries the destination-register tag to the writeback mux.
//
//   Ports:
//     clk       system clock
//     reset_n   asynchronous active-low reset
//     bus       nios2_cpu_mul_combine_if.slave
//                 in_p1/in_p2/in_p3/in_tag/in_valid -> in_ready
//                 out_result/out_tag/out_par/out_valid <- out_ready
//                 flush     kills every in-flight operation
//                 done_cnt  wrapping count of results taken by the consumer
//
//   Build option:
//     MUL_COMBINE_PARITY_EN  when defined, out_par carries the even parity of
//                            each result byte; otherwise out_par is 4'b0000.
// ---------------------------------------------------------------------------
module nios2_cpu_mul_combine #(
    parameter int HALF_W = 16,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios2_cpu_mul_combine_if.slave bus
);
    localparam int W = 2 * HALF_W;

    // Stage 1 state
    logic              s1_valid;
    logic [W-1:0]      s1_lo;
    logic [HALF_W-1:0] s1_mid;
    logic [TAG_W-1:0]  s1_tag;

    // Stage 2 (output) state
    logic              out_valid_q;
    logic [W-1:0]      out_result_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic [3:0]        out_par_q;
    logic [CNT_W-1:0]  done_cnt_q;

    // Handshake terms
    logic              s2_adv;
    logic              s2_load;
    logic              s1_accept;
    logic              out_fire;
    logic              in_ready_c;

    // Datapath terms
    logic [HALF_W-1:0] mid_sum;
    logic [W-1:0]      result_next;
    logic [3:0]        par_next;

    // Only the low halves of the cross products reach the low word.
    logic              unused_hi;
    assign unused_hi = ^{bus.in_p2[W-1:HALF_W], bus.in_p3[W-1:HALF_W]};

    // Stage 1 can move on when stage 2 is empty or being drained this cycle.
    assign s2_adv     = s1_valid & (~out_valid_q | bus.out_ready);
    // Flush closes the input for its cycle so the presented op is dropped.
    assign in_ready_c = ~bus.flush & (~s1_valid | s2_adv);
    assign s1_accept  = bus.in_valid & in_ready_c;
    // Data registers hold through a flush, so the load is gated too.
    assign s2_load    = s2_adv & ~bus.flush;
    // A consumer handshake counts even in a flush cycle.
    assign out_fire   = out_valid_q & bus.out_ready;

    // NOTE: every signal written in always_comb gets a value before any
    // branch, otherwise a latch is inferred.
    always_comb begin
        mid_sum     = '0;
        result_next = '0;
        par_next    = '0;
        mid_sum     = bus.in_p2[HALF_W-1:0] + bus.in_p3[HALF_W-1:0];
        result_next = s1_lo + {s1_mid, {HALF_W{1'b0}}};
`ifdef MUL_COMBINE_PARITY_EN
        for (int i = 0; i < 4; i++) begin
            par_next[i] = ^result_next[8*i +: 8];
        end
`endif
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_mid   <= '0;
            s1_tag   <= '0;
        end else begin
            if (bus.flush) begin
                s1_valid <= 1'b0;
            end else if (s1_accept) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_accept) begin
                s1_lo  <= bus.in_p1;
                s1_mid <= mid_sum;
                s1_tag <= bus.in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_par_q    <= '0;
        end else begin
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (s2_load) begin
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (s2_load) begin
                out_result_q <= result_next;
                out_tag_q    <= s1_tag;
                out_par_q    <= par_next;
            end
        end
    end

    // Wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt_q <= '0;
        end else if (out_fire) begin
            done_cnt_q <= done_cnt_q + 1'b1;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_par    = out_par_q;
    assign bus.done_cnt   = done_cnt_q;
endmodule
